program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Write-side counterpart of the program memory. Receives a byte stream, for example from a UART receiver.
- Assembles each group of bytes into one DATA_WIDTH instruction word and writes it to sequential word addresses of a writable program RAM.
- Verifies a trailing XOR checksum byte at the end of the load.
- Sits between the serial/debug link and the program memory's write port. The CPU is held off while Busy_o=1.

Parameters:
- MEMORY_DEPTH, 64: number of words in program memory.
- DATA_WIDTH, 32: word width in bits. Must be a multiple of 8. Bytes per word BPW = DATA_WIDTH/8.

Ports:
- clk  input  1  system clock. All logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Start_i  input  1  one-cycle pulse that begins a load. Sampled only in IDLE.
- Word_Count_i  input  $clog2(MEMORY_DEPTH)+1  number of words to load. Sampled with Start_i.
- Byte_i  input  8  incoming data byte.
- Byte_Valid_i  input  1  Byte_i is valid this cycle.
- Ready_o  output  1  loader accepts bytes (state LOAD or CHECK).
- Busy_o  output  1  load in progress (state not IDLE/DONE).
- Wr_En_o  output  1  one-cycle program-memory write strobe.
- Wr_Address_o  output  $clog2(MEMORY_DEPTH)  word address of the write.
- Wr_Data_o  output  DATA_WIDTH  word to write.
- Done_o  output  1  one-cycle pulse at the end of a load (success or error).
- Error_o  output  1  sticky error flag. Cleared by the next accepted Start_i or by reset.

Behaviour:
- FSM states: IDLE, LOAD, CHECK, DONE.
- Reset: state=IDLE. All outputs are 0, including Wr_Address_o and Wr_Data_o. The byte counter, word counter, assembly register and checksum are cleared. Reset mid-load aborts immediately; Wr_En_o is 0 in the cycle after reset; already-written RAM words are left as they are.
- IDLE, Start_i=1: clear Error_o, latch Word_Count_i into N, clear the checksum and counters.
  - If N==0 or N>MEMORY_DEPTH: go to DONE with Error_o=1. No writes occur.
  - Otherwise go to LOAD.
- In IDLE, Byte_Valid_i is ignored.
- LOAD: each Byte_Valid_i=1 cycle shifts Byte_i into the assembly register, big-endian. The first byte of a word lands in bits [DATA_WIDTH-1:DATA_WIDTH-8]. The checksum is XORed with Byte_i.
- Word write: on the cycle the BPW-th byte is accepted, the next cycle shows:
  - Wr_En_o=1 for exactly 1 cycle.
  - Wr_Data_o = assembled word.
  - Wr_Address_o = word index (0..N-1).
  - Latency: 1 clock from the last byte sampled to the write strobe.
- Wr_Data_o and Wr_Address_o hold their values after the strobe until the next write.
- The loader never stalls; Ready_o=1 throughout LOAD and CHECK. A byte arriving in the same cycle as Wr_En_o is accepted as byte 0 of the next word.
- After word index N-1 is completed (last byte accepted), the state goes to CHECK on that same edge. The final write strobe still appears in the following cycle.
- CHECK: the next Byte_Valid_i byte is compared with the checksum of all N*BPW data bytes.
  - On mismatch, Error_o=1.
  - On a match or a mismatch, go to DONE. That byte is not written to memory.
- DONE: Done_o=1 for one cycle, Busy_o=0, Ready_o=0, then go to IDLE.
- Start_i outside IDLE is ignored. No restart mid-load.
- The address counter never wraps, because N≤MEMORY_DEPTH is enforced at start.
- Error_o persists through IDLE until the next accepted Start_i.

Test Plan:
- Reset mid-operation: reset after 3 of 8 bytes -> next cycle Wr_En_o=0, Busy_o=0, Ready_o=0, all outputs 0. A following Start_i with N=1 starts a clean load at address 0.
- Single word: Start_i, N=1, bytes 0x20,0x08,0x00,0x05, then checksum 0x2D ->
  - Wr_En_o pulses once, 1 cycle after byte 4, with address 0 and data 0x20080005.
  - Then Done_o=1 with Error_o=0.
- Back-to-back bytes: N=3, 12 bytes on 12 consecutive cycles ->
  - Three strobes at addresses 0,1,2, each 1 cycle after bytes 4, 8 and 12.
  - No byte lost when Byte_Valid_i coincides with Wr_En_o.
- Bad checksum: N=2, valid data, checksum byte XORed with 0x01 -> both words written, then Done_o=1 with Error_o=1. Error_o stays 1 until the next Start_i.
- Illegal count: N=0 and N=65 (MEMORY_DEPTH=64) -> no Wr_En_o, Done_o one cycle after Start_i, Error_o=1.
- Full depth: N=64 with gapped Byte_Valid_i (random idle cycles) -> last write at address 63 and no wrap to 0. Start_i pulses mid-load have no effect.

Source files
------------

// File: rtl/program_loader_if.sv
// Byte-stream and program-memory write bundle for program_loader.
// master = byte source / memory side, slave = the loader itself.
interface program_loader_if #(
  parameter int unsigned MEMORY_DEPTH = 64,
  parameter int unsigned DATA_WIDTH   = 32
) ();

  logic                            Start_i;
  logic [$clog2(MEMORY_DEPTH):0]   Word_Count_i;
  logic [7:0]                      Byte_i;
  logic                            Byte_Valid_i;
  logic                            Ready_o;
  logic                            Busy_o;
  logic                            Wr_En_o;
  logic [$clog2(MEMORY_DEPTH)-1:0] Wr_Address_o;
  logic [DATA_WIDTH-1:0]           Wr_Data_o;
  logic                            Done_o;
  logic                            Error_o;

  modport slave (
    input  Start_i, Word_Count_i, Byte_i, Byte_Valid_i,
    output Ready_o, Busy_o, Wr_En_o, Wr_Address_o, Wr_Data_o, Done_o, Error_o
  );

  modport master (
    output Start_i, Word_Count_i, Byte_i, Byte_Valid_i,
    input  Ready_o, Busy_o, Wr_En_o, Wr_Address_o, Wr_Data_o, Done_o, Error_o
  );

endinterface

// File: rtl/program_loader.sv
// Program loader: assembles a byte stream into big-endian words, writes them to
// sequential program-memory addresses and verifies a trailing XOR checksum.
module program_loader #(
  parameter int unsigned MEMORY_DEPTH = 64,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input logic             clk,
  input logic             reset,
  program_loader_if.slave bus
);

  localparam int unsigned BPW      = DATA_WIDTH / 8;
  localparam int unsigned AddrW    = $clog2(MEMORY_DEPTH);
  localparam int unsigned CntW     = AddrW + 1;
  localparam int unsigned ByteCntW = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [ByteCntW-1:0] LastByte = ByteCntW'(BPW - 1);
  localparam logic [CntW-1:0]     MaxWords = CntW'(MEMORY_DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StCheck, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       n_q, n_d;
  logic [CntW-1:0]       idx_q, idx_d;
  logic [ByteCntW-1:0]   bcnt_q, bcnt_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic [7:0]            csum_q, csum_d;
  logic                  wr_en_q, wr_en_d;
  logic [AddrW-1:0]      wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  error_q, error_d;
  logic [DATA_WIDTH-1:0] asm_next;
  logic [CntW-1:0]       idx_inc;

  // First byte of a word ends up in the top byte after BPW shifts.
  assign asm_next = (asm_q << 8) | DATA_WIDTH'(bus.Byte_i);
  assign idx_inc  = idx_q + CntW'(1);

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      n_q       <= '0;
      idx_q     <= '0;
      bcnt_q    <= '0;
      asm_q     <= '0;
      csum_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      bcnt_q    <= bcnt_d;
      asm_q     <= asm_d;
      csum_q    <= csum_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      error_q   <= error_d;
    end
  end

  // Next-state logic: start/count validation, byte assembly, word writes, checksum.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    bcnt_d    = bcnt_q;
    asm_d     = asm_q;
    csum_d    = csum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    error_d   = error_q;

    unique case (state_q)
      StIdle: begin
        if (bus.Start_i) begin
          error_d = 1'b0;
          n_d     = bus.Word_Count_i;
          idx_d   = '0;
          bcnt_d  = '0;
          asm_d   = '0;
          csum_d  = '0;
          // Rejecting out-of-range counts here means the address never wraps.
          if (bus.Word_Count_i == '0 || bus.Word_Count_i > MaxWords) begin
            error_d = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StLoad;
          end
        end
      end

      StLoad: begin
        if (bus.Byte_Valid_i) begin
          asm_d  = asm_next;
          csum_d = csum_q ^ bus.Byte_i;
          if (bcnt_q == LastByte) begin
            bcnt_d    = '0;
            wr_en_d   = 1'b1;
            wr_addr_d = idx_q[AddrW-1:0];
            wr_data_d = asm_next;
            idx_d     = idx_inc;
            if (idx_inc == n_q) begin
              state_d = StCheck;
            end
          end else begin
            bcnt_d = bcnt_q + ByteCntW'(1);
          end
        end
      end

      StCheck: begin
        if (bus.Byte_Valid_i) begin
          if (bus.Byte_i != csum_q) begin
            error_d = 1'b1;
          end
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Status outputs decode directly from the state; write port is registered.
  always_comb begin
    bus.Ready_o      = (state_q == StLoad) || (state_q == StCheck);
    bus.Busy_o       = (state_q == StLoad) || (state_q == StCheck);
    bus.Done_o       = (state_q == StDone);
    bus.Error_o      = error_q;
    bus.Wr_En_o      = wr_en_q;
    bus.Wr_Address_o = wr_addr_q;
    bus.Wr_Data_o    = wr_data_q;
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
module tb_program_loader;

  localparam int unsigned Depth = 64;
  localparam int unsigned Width = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] stim [256];

  program_loader_if #(.MEMORY_DEPTH(Depth), .DATA_WIDTH(Width)) bus ();

  program_loader #(.MEMORY_DEPTH(Depth), .DATA_WIDTH(Width)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_wr_en"}, 64'(bus.Wr_En_o), 64'd0);
    check({tag, "_busy"}, 64'(bus.Busy_o), 64'd0);
    check({tag, "_ready"}, 64'(bus.Ready_o), 64'd0);
    check({tag, "_done"}, 64'(bus.Done_o), 64'd0);
    check({tag, "_error"}, 64'(bus.Error_o), 64'd0);
    check({tag, "_addr"}, 64'(bus.Wr_Address_o), 64'd0);
    check({tag, "_data"}, 64'(bus.Wr_Data_o), 64'd0);
  endtask

  // Full load: start, n words from stim[], then checksum (optionally corrupted).
  task automatic run_load(input int n, input bit gapped, input bit bad, input bit mid_start);
    logic [7:0]  csum;
    logic [31:0] word;
    int          gaps;
    csum = 8'h00;
    word = 32'h0;
    bus.Start_i      = 1'b1;
    bus.Word_Count_i = 7'(n);
    @(negedge clk);
    bus.Start_i = 1'b0;
    check("start_busy", 64'(bus.Busy_o), 64'd1);
    check("start_ready", 64'(bus.Ready_o), 64'd1);
    check("start_err_clr", 64'(bus.Error_o), 64'd0);
    for (int i = 0; i < n * 4; i++) begin
      if (gapped) begin
        gaps = int'($urandom_range(0, 2));
        for (int g = 0; g < gaps; g++) begin
          bus.Start_i      = mid_start;
          bus.Word_Count_i = 7'd1;
          @(negedge clk);
          bus.Start_i = 1'b0;
          check("gap_wr_en", 64'(bus.Wr_En_o), 64'd0);
          check("gap_busy", 64'(bus.Busy_o), 64'd1);
        end
      end
      bus.Byte_i       = stim[i];
      bus.Byte_Valid_i = 1'b1;
      csum             = csum ^ stim[i];
      word             = {word[23:0], stim[i]};
      @(negedge clk);
      bus.Byte_Valid_i = 1'b0;
      if (i % 4 == 3) begin
        check("wr_en", 64'(bus.Wr_En_o), 64'd1);
        check("wr_addr", 64'(bus.Wr_Address_o), 64'(i / 4));
        check("wr_data", 64'(bus.Wr_Data_o), 64'(word));
      end else begin
        check("no_wr_en", 64'(bus.Wr_En_o), 64'd0);
      end
    end
    check("chk_ready", 64'(bus.Ready_o), 64'd1);
    bus.Byte_i       = bad ? (csum ^ 8'h01) : csum;
    bus.Byte_Valid_i = 1'b1;
    @(negedge clk);
    bus.Byte_Valid_i = 1'b0;
    check("done_pulse", 64'(bus.Done_o), 64'd1);
    check("done_error", 64'(bus.Error_o), 64'(bad));
    check("done_busy", 64'(bus.Busy_o), 64'd0);
    check("done_ready", 64'(bus.Ready_o), 64'd0);
    check("done_wr_en", 64'(bus.Wr_En_o), 64'd0);
    @(negedge clk);
    check("idle_done", 64'(bus.Done_o), 64'd0);
    check("idle_error", 64'(bus.Error_o), 64'(bad));
  endtask

  task automatic illegal(input int n, input string tag);
    bus.Start_i      = 1'b1;
    bus.Word_Count_i = 7'(n);
    @(negedge clk);
    bus.Start_i = 1'b0;
    check({tag, "_done"}, 64'(bus.Done_o), 64'd1);
    check({tag, "_error"}, 64'(bus.Error_o), 64'd1);
    check({tag, "_busy"}, 64'(bus.Busy_o), 64'd0);
    check({tag, "_wr_en"}, 64'(bus.Wr_En_o), 64'd0);
    @(negedge clk);
    check({tag, "_idle_done"}, 64'(bus.Done_o), 64'd0);
    check({tag, "_idle_error"}, 64'(bus.Error_o), 64'd1);
    check({tag, "_idle_wr_en"}, 64'(bus.Wr_En_o), 64'd0);
  endtask

  initial begin
    reset            = 1'b1;
    bus.Start_i      = 1'b0;
    bus.Word_Count_i = '0;
    bus.Byte_i       = '0;
    bus.Byte_Valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;
    @(negedge clk);
    check_quiet("idle");

    // Abort a two-word load after three bytes.
    bus.Start_i      = 1'b1;
    bus.Word_Count_i = 7'd2;
    @(negedge clk);
    bus.Start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.Byte_i       = 8'(8'hA0 + i);
      bus.Byte_Valid_i = 1'b1;
      @(negedge clk);
    end
    bus.Byte_Valid_i = 1'b0;
    reset            = 1'b1;
    @(negedge clk);
    check_quiet("midreset");
    reset = 1'b0;
    @(negedge clk);

    // Single word after the abort: must land at address 0.
    stim[0] = 8'h20;
    stim[1] = 8'h08;
    stim[2] = 8'h00;
    stim[3] = 8'h05;
    run_load(1, 1'b0, 1'b0, 1'b0);
    check("single_hold_addr", 64'(bus.Wr_Address_o), 64'd0);
    check("single_hold_data", 64'(bus.Wr_Data_o), 64'h20080005);

    // Three words, bytes on consecutive cycles.
    for (int i = 0; i < 12; i++) stim[i] = 8'(8'h11 * (i + 1));
    run_load(3, 1'b0, 1'b0, 1'b0);

    // Corrupted checksum; error must persist through idle.
    for (int i = 0; i < 8; i++) stim[i] = 8'(8'h3C ^ (i * 5));
    run_load(2, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("sticky_error", 64'(bus.Error_o), 64'd1);

    illegal(0, "n0");
    illegal(65, "n65");

    // Full depth with idle gaps and ignored mid-load starts.
    for (int i = 0; i < 256; i++) stim[i] = 8'(i * 7 + 3);
    run_load(64, 1'b1, 1'b0, 1'b1);
    check("full_hold_addr", 64'(bus.Wr_Address_o), 64'd63);
    @(negedge clk);
    check("full_no_wrap_wr", 64'(bus.Wr_En_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
